mips_instr_encoder: RTL and testbench

MIPS_INSTR_ENCODER -- requirements
Module: mips_instr_encoder

---
 rtl/enc_pkg.sv | 39 +++
 rtl/enc_fifo.sv | 67 ++++++
 rtl/mips_instr_encoder.sv | 105 ++++++++++
 tb/tb_mips_instr_encoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// enc_pkg: shared constants for the MIPS instruction encoder.
// Holds the instruction-class codes accepted on class3, the MIPS opcodes
// and R-type funct used to build instruction words, and the default
// output-buffer depth. The optional illegal-class checking feature is
// selected by the ENC_CHECK_EN macro (see mips_instr_encoder).
package enc_pkg;

  // Default number of output buffer entries (power of two, at least 2).
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // Instruction classes presented on class3; codes 5..7 are illegal.
  typedef enum logic [2:0] {
    CLS_RADD = 3'd0,
    CLS_LW   = 3'd1,
    CLS_SW   = 3'd2,
    CLS_BEQ  = 3'd3,
    CLS_J    = 3'd4
  } instr_class_e;

  // Primary opcodes (bits 31:26 of the instruction word).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type function code for ADD and the shift amount it carries.
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [4:0] SHAMT_ZERO = 5'd0;

  // Word pushed for an illegal class when checking is disabled (MIPS NOP).
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // True for the five class codes the encoder knows how to build.
  function automatic logic class_is_legal(input logic [2:0] cls);
    return (cls <= 3'(CLS_J));
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// enc_fifo: synchronous FIFO buffering encoded instruction words.
// Single clock, synchronous active-high reset. Pointers wrap modulo DEPTH
// (DEPTH must be a power of two). The head word is presented
// combinationally on rdata and reads as zero while the FIFO is empty.
// A push while full and a pop while empty are ignored.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = cnt;

  // Head of queue; zero when nothing is buffered so consumers never see stale data.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage write: only accepted pushes land, never during reset.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: builds 32-bit MIPS instruction words from field sets
// and buffers them in an enc_fifo for a downstream consumer.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid && ready are both 1. The producer holds its fields stable while
// valid=1 and ready=0. in_ready depends only on buffer occupancy
// (not full), never on out_ready, so a pop in a full cycle does not open a
// same-cycle push. out_valid is 1 exactly while the buffer holds a word,
// and out_instr stays fixed until that word is taken.
//
// Optional feature macro: ENC_CHECK_EN.
//   defined   - an illegal class (5..7) is accepted but dropped, and err
//               pulses for one cycle on the following cycle.
//   undefined - an illegal class is buffered as a NOP (all zeros) and err
//               is held at 0.
module mips_instr_encoder
  import enc_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  class3,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err,
  output logic [2:0]  count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  instr_class_e  cls;
  logic [31:0]   enc_word;
  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign cls    = instr_class_e'(class3);
  assign legal  = class_is_legal(class3);
  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Combinational encoder: fields not used by a class are ignored; illegal codes give a NOP.
  always_comb begin
    enc_word = NOP_WORD;
    case (cls)
      CLS_RADD: enc_word = {OP_RTYPE, rs, rt, rd, SHAMT_ZERO, FUNCT_ADD};
      CLS_LW:   enc_word = {OP_LW, rs, rt, imm};
      CLS_SW:   enc_word = {OP_SW, rs, rt, imm};
      CLS_BEQ:  enc_word = {OP_BEQ, rs, rt, imm};
      CLS_J:    enc_word = {OP_J, target};
      default:  enc_word = NOP_WORD;
    endcase
  end

`ifdef ENC_CHECK_EN
  // Illegal classes are swallowed: accepted for flow control, never buffered.
  assign push = accept && legal;

  // Flag a swallowed illegal class one cycle after it was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= accept && !legal;
    end
  end
`else
  // Every accepted field set is buffered; illegal ones already encode as a NOP.
  assign push = accept;
  assign err  = 1'b0;
`endif

  enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (enc_word),
    .pop   (pop),
    .rdata (out_instr),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign count     = 3'(fifo_count);

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: directed and randomized checks of the MIPS
// instruction encoder against a queue-based reference model that builds
// instruction words arithmetically from opcode and field positions.
module tb_mips_instr_encoder;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  class3;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [2:0]  count;

  always #5 clk = ~clk;

  mips_instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .class3    (class3),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .imm       (imm),
    .target    (target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .err       (err),
    .count     (count)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic        exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoding: opcode * 2^26 plus each field scaled to its bit position.
  function automatic logic [31:0] ref_encode(input int cls, input longint f_rs, input longint f_rt,
                                             input longint f_rd, input longint f_imm, input longint f_tgt);
    longint v;
    case (cls)
      0: v = f_rs * 2**21 + f_rt * 2**16 + f_rd * 2**11 + 32;
      1: v = 64'd35 * 2**26 + f_rs * 2**21 + f_rt * 2**16 + f_imm;
      2: v = 64'd43 * 2**26 + f_rs * 2**21 + f_rt * 2**16 + f_imm;
      3: v = 64'd4 * 2**26 + f_rs * 2**21 + f_rt * 2**16 + f_imm;
      4: v = 64'd2 * 2**26 + f_tgt;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // One clock: compare outputs with the model, take the edge, advance the model.
  task automatic cycle();
    bit          acc;
    bit          pop;
    logic [31:0] head;
    head = 32'h0;
    if (exp_q.size() != 0) head = exp_q[0];
    check("count", 32'(count), 32'(exp_q.size()));
    check("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("out_instr", out_instr, head);
    check("err", 32'(err), 32'(exp_err));
    acc = in_valid && (exp_q.size() < DEPTH);
    pop = out_ready && (exp_q.size() > 0);
    @(posedge clk);
    exp_err = 1'b0;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        if (class3 > 3'd4) begin
`ifdef ENC_CHECK_EN
          exp_err = 1'b1;
`else
          exp_q.push_back(32'h0);
`endif
        end else begin
          exp_q.push_back(ref_encode(int'(class3), longint'(rs), longint'(rt), longint'(rd),
                                     longint'(imm), longint'(target)));
        end
      end
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_fields(input logic [2:0] c, input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] d, input logic [15:0] i, input logic [25:0] g);
    class3 = c; rs = s; rt = t; rd = d; imm = i; target = g;
  endtask

  task automatic set_random_fields(input int illegal_pct);
    if ($urandom_range(99) < illegal_pct) class3 = 3'($urandom_range(7, 5));
    else class3 = 3'($urandom_range(4));
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    imm = 16'($urandom); target = 26'($urandom);
  endtask

  // Push one field set into an empty encoder, check the word, then drain it.
  task automatic send_one(input string tag, input logic [31:0] want);
    in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    check(tag, out_instr, want);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    check("reset_count", 32'(count), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_instr", out_instr, 32'h0);

    // Known-good encodings.
    set_fields(3'd0, 5'd17, 5'd18, 5'd16, 16'h0, 26'h0);
    send_one("radd_word", 32'h0232_8020);
    set_fields(3'd1, 5'd17, 5'd16, 5'd0, 16'h0020, 26'h0);
    send_one("lw_word", 32'h8E30_0020);
    set_fields(3'd2, 5'd17, 5'd16, 5'd0, 16'h0020, 26'h0);
    send_one("sw_word", 32'hAE30_0020);
    set_fields(3'd3, 5'd16, 5'd17, 5'd0, 16'd200, 26'h0);
    send_one("beq_word", 32'h1211_00C8);
    set_fields(3'd4, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'd1000);
    send_one("j_word", 32'h0800_03E8);

    // Fill with consumer stalled: fifth word must stall, then drain in order.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_random_fields(0);
      cycle();
    end
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    set_random_fields(0);
    out_ready = 1'b1;
    cycle();
    check("full_pop_no_push", 32'(count), 32'd3);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    out_ready = 1'b0;

    // Illegal class.
    set_fields(3'd6, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h155_5555);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
`ifdef ENC_CHECK_EN
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_count", 32'(count), 32'd0);
`else
    check("illegal_count", 32'(count), 32'd1);
    check("illegal_nop", out_instr, 32'h0);
    check("illegal_err", 32'(err), 32'd0);
`endif
    out_ready = 1'b1;
    cycle();
    cycle();
    out_ready = 1'b0;

    // Reset with three words buffered and an acceptance in the reset cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_random_fields(0);
      cycle();
    end
    check("pre_reset_count", 32'(count), 32'd3);
    rst = 1'b1;
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    check("post_reset_count", 32'(count), 32'd0);
    check("post_reset_out_valid", 32'(out_valid), 32'd0);
    check("post_reset_out_instr", out_instr, 32'h0);
    cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(99) < 60);
      out_ready = ($urandom_range(99) < 50);
      rst       = ($urandom_range(99) < 2);
      set_random_fields(10);
      cycle();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
